if_stage: RTL and testbench

- Instruction fetch stage, directly downstream of pc_control.
- Holds the instruction memory, which the debug loader fills through a write port.
- Reads the word at the incoming PC and captures instruction, PC and PC+4 into the IF/ID pipeline register for the decode stage.
- Detects the HALT instruction and drives a sticky halt back to pc_control's i_halt.

---
 rtl/if_stage.sv | 82 ++++++++
 tb/tb_if_stage.sv | 129 ++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch: instruction memory with a loader write port, feeding the IF/ID register and a sticky halt.
// Latency: one cycle from i_pc to IF/ID; o_halt rises together with the HALT word in IF/ID.
// Backpressure: i_stall holds IF/ID, i_flush bubbles it, halt bubbles until reset; loader writes are never blocked.
module if_stage #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_imem_we,
    input  logic [31:0] i_imem_waddr,
    input  logic [31:0] i_imem_wdata,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid,
    output logic        o_halt
);
    localparam int AW = $clog2(IMEM_DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    typedef enum logic {RUN, HALTED} state_t;

    logic [31:0] imem [IMEM_DEPTH];
    logic        fetch_in_range;
    logic        wr_in_range;
    logic [31:0] fetch_word;
    ifid_t       ifid_q, ifid_d;
    state_t      state_q, state_d;

    assign fetch_in_range = (i_pc[31:AW+2] == '0);
    assign wr_in_range    = (i_imem_waddr[31:AW+2] == '0);
    // Read is combinational, so a same-edge loader write is seen only on the next fetch.
    assign fetch_word     = fetch_in_range ? imem[i_pc[AW+1:2]] : NOP_INSTR;

    always_ff @(posedge i_clk) begin
        if (i_imem_we && wr_in_range)
            imem[i_imem_waddr[AW+1:2]] <= i_imem_wdata;
    end

    always_comb begin
        ifid_d  = ifid_q;
        state_d = state_q;
        if (i_flush || state_q == HALTED) begin
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
        end else if (!i_stall) begin
            ifid_d.instr    = fetch_word;
            ifid_d.pc       = i_pc;
            ifid_d.pc_plus4 = i_pc + 32'd4;
            ifid_d.valid    = fetch_in_range;
            if (fetch_in_range && fetch_word == HALT_INSTR)
                state_d = HALTED;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            ifid_q  <= '{instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0, valid: 1'b0};
            state_q <= RUN;
        end else begin
            ifid_q  <= ifid_d;
            state_q <= state_d;
        end
    end

    assign o_instr    = ifid_q.instr;
    assign o_pc       = ifid_q.pc;
    assign o_pc_plus4 = ifid_q.pc_plus4;
    assign o_valid    = ifid_q.valid;
    assign o_halt     = (state_q == HALTED);
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: loader, fetch latency, stall/flush, halt, out-of-range and write/fetch collision.
module tb_if_stage;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_pc;
    logic        i_stall;
    logic        i_flush;
    logic        i_imem_we;
    logic [31:0] i_imem_waddr;
    logic [31:0] i_imem_wdata;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic        o_valid;
    logic        o_halt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    if_stage dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_pc         (i_pc),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .i_imem_we    (i_imem_we),
        .i_imem_waddr (i_imem_waddr),
        .i_imem_wdata (i_imem_wdata),
        .o_instr      (o_instr),
        .o_pc         (o_pc),
        .o_pc_plus4   (o_pc_plus4),
        .o_valid      (o_valid),
        .o_halt       (o_halt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] pc4, input logic valid, input logic halt);
        check({tag, ".instr"}, o_instr, instr);
        check({tag, ".pc"}, o_pc, pc);
        check({tag, ".pc4"}, o_pc_plus4, pc4);
        check({tag, ".valid"}, {31'd0, o_valid}, {31'd0, valid});
        check({tag, ".halt"}, {31'd0, o_halt}, {31'd0, halt});
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        i_imem_we    = 1'b1;
        i_imem_waddr = addr;
        i_imem_wdata = data;
        tick();
        i_imem_we    = 1'b0;
    endtask

    initial begin
        i_reset = 1'b0; i_pc = 32'd0; i_stall = 1'b0; i_flush = 1'b0;
        i_imem_we = 1'b0; i_imem_waddr = 32'd0; i_imem_wdata = 32'd0;
        tick();
        check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Loader works while reset is held.
        load(32'h00, 32'h2001_0005);
        load(32'h04, 32'h2002_0007);
        load(32'h08, 32'hFFFF_FFFF);

        i_reset = 1'b1; i_pc = 32'h0; tick();
        check_ifid("fetch0", 32'h2001_0005, 32'h0, 32'h4, 1'b1, 1'b0);
        i_pc = 32'h4; tick();
        check_ifid("fetch4", 32'h2002_0007, 32'h4, 32'h8, 1'b1, 1'b0);

        i_pc = 32'h0; tick();
        i_stall = 1'b1; i_pc = 32'h4;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_ifid($sformatf("stall%0d", k), 32'h2001_0005, 32'h0, 32'h4, 1'b1, 1'b0);
        end
        i_flush = 1'b1; tick();
        check_ifid("flush_stall", 32'h0, 32'h0, 32'h4, 1'b0, 1'b0);

        i_pc = 32'h8; tick();
        check_ifid("flush_halt", 32'h0, 32'h0, 32'h4, 1'b0, 1'b0);
        i_flush = 1'b0; i_stall = 1'b0;

        tick();
        check_ifid("halt_load", 32'hFFFF_FFFF, 32'h8, 32'hC, 1'b1, 1'b1);
        i_pc = 32'hC; tick();
        check_ifid("halt_bubble", 32'h0, 32'h8, 32'hC, 1'b0, 1'b1);
        i_pc = 32'h0;
        for (int k = 0; k < 10; k++) tick();
        check_ifid("halt_sticky", 32'h0, 32'h8, 32'hC, 1'b0, 1'b1);

        i_reset = 1'b0; tick();
        check_ifid("halt_reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        i_reset = 1'b1; i_pc = 32'h0; tick();
        check_ifid("refetch0", 32'h2001_0005, 32'h0, 32'h4, 1'b1, 1'b0);

        // Out-of-range fetch with an out-of-range loader write in the same cycle.
        i_pc = 32'h400;
        load(32'h400, 32'hDEAD_BEEF);
        check_ifid("oor_fetch", 32'h0, 32'h400, 32'h404, 1'b0, 1'b0);
        i_pc = 32'h0; tick();
        check_ifid("no_alias", 32'h2001_0005, 32'h0, 32'h4, 1'b1, 1'b0);

        i_pc = 32'h4;
        load(32'h04, 32'h1234_5678);
        check_ifid("wr_collide", 32'h2002_0007, 32'h4, 32'h8, 1'b1, 1'b0);
        tick();
        check_ifid("wr_after", 32'h1234_5678, 32'h4, 32'h8, 1'b1, 1'b0);

        i_pc = 32'hFFFF_FFFC; tick();
        check_ifid("pc_wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
